// File: rtl/draw_scheduler_pkg.sv
// draw_scheduler_pkg: shared state encoding and object indices for the per-frame draw sequencer
package draw_scheduler_pkg;
  localparam int NUM_OBJ = 5;
  localparam int OBJ_PLAYER = 0;
  localparam int OBJ_E0 = 1;
  localparam int OBJ_E1 = 2;
  localparam int OBJ_E2 = 3;
  localparam int OBJ_E3 = 4;
  typedef enum logic [2:0] {IDLE, E_ISSUE, E_WAIT, LOAD, D_ISSUE, D_WAIT, DONE} state_t;
endpackage

// File: rtl/draw_scheduler.sv
// draw_scheduler: per-frame erase/load/redraw sequencer for the object mux and rectangle plotter
//   in:  clk, reset (sync, active-low), frame_tick, alive[NUM_OBJ], plot_done
//   out: control_signal[IDX_W], load, erase, plot_start, busy, frame_done, overrun, timeout_err
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int NUM_OBJ = draw_scheduler_pkg::NUM_OBJ,
  parameter int IDX_W = 4,
  parameter int PLOT_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic [NUM_OBJ-1:0] alive,
  input  logic               plot_done,
  output logic [IDX_W-1:0]   control_signal,
  output logic               load,
  output logic               erase,
  output logic               plot_start,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err
);
  localparam int TW = $clog2(PLOT_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(PLOT_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] I_LAST = IDX_W'(NUM_OBJ - 1);
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [NUM_OBJ-1:0] drawn, sel;
  logic [TW-1:0] tcnt;
  logic pending, issue_st, wait_st, obj_on, last, t_hit, advance;
  always_comb begin
    sel = NUM_OBJ'(1) << idx;
    obj_on = |(drawn & sel);
    issue_st = state == E_ISSUE || state == D_ISSUE;
    wait_st = state == E_WAIT || state == D_WAIT;
    last = idx == I_LAST;
    // a plot_done coincident with plot_start is not seen: done only counts in WAIT
    t_hit = wait_st && !plot_done && tcnt == T_LAST;
    advance = (issue_st && !obj_on) || (wait_st && (plot_done || tcnt == T_LAST));
    state_n = state;
    unique case (state)
      IDLE:    state_n = frame_tick || pending ? E_ISSUE : IDLE;
      E_ISSUE: state_n = obj_on ? E_WAIT : last ? LOAD : E_ISSUE;
      E_WAIT:  state_n = !advance ? E_WAIT : last ? LOAD : E_ISSUE;
      LOAD:    state_n = D_ISSUE;
      D_ISSUE: state_n = obj_on ? D_WAIT : last ? DONE : D_ISSUE;
      D_WAIT:  state_n = !advance ? D_WAIT : last ? DONE : D_ISSUE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign control_signal = idx;
  assign load = state == LOAD;
  assign erase = state == E_ISSUE || state == E_WAIT;
  assign plot_start = issue_st && obj_on;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      drawn <= '0;
      pending <= 1'b0;
      tcnt <= '0;
      overrun <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state inside {IDLE, LOAD, DONE}) idx <= '0;
      else if (advance && !last) idx <= idx + 1'b1;
      tcnt <= wait_st ? tcnt + 1'b1 : '0;
      // an object whose draw timed out is treated as not on screen, so it is not erased next frame
      if (state == LOAD) drawn <= alive;
      else if (t_hit && state == D_WAIT) drawn <= drawn & ~sel;
      if (t_hit) timeout_err <= 1'b1;
      if (state == IDLE) pending <= 1'b0;
      else if (frame_tick) begin
        if (pending) overrun <= 1'b1;
        else pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_draw_scheduler.sv
// tb_draw_scheduler: schedule-model checker for draw_scheduler with directed frames
module tb_draw_scheduler;
  import draw_scheduler_pkg::*;
  localparam int PT = 1024;
  localparam int INF = 32'h7fffffff;
  typedef struct packed {
    logic [3:0] cs;
    logic ld, er, st, bz, fd;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic frame_tick = 1'b0;
  logic [4:0] alive = '0;
  logic plot_done = 1'b0;
  logic [3:0] control_signal;
  logic load, erase, plot_start, busy, frame_done, overrun, timeout_err;
  draw_scheduler #(.NUM_OBJ(5), .IDX_W(4), .PLOT_TIMEOUT(PT)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .alive(alive), .plot_done(plot_done),
    .control_signal(control_signal), .load(load), .erase(erase), .plot_start(plot_start),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int vectors = 0, miscompares = 0;
  int m_terr_cyc = INF, m_ovr_cyc = INF;
  int gen_cyc, tick_cyc, fd_cyc;
  int plat = 3, due = -1;
  logic [4:0] m_drawn = '0;
  bit chk_en = 0;
  rec_t q[$];
  rec_t r;
  logic [10:0] act, expv;
  string log_s = "";
  task automatic check_int(input string name, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, a, e);
    end
  endtask
  task automatic check_str(input string name, input string a, input string e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got \"%s\" want \"%s\"", name, a, e);
    end
  endtask
  task automatic put(input int cs, input bit ld, input bit er, input bit st, input bit bz, input bit fd);
    rec_t x;
    x.cs = 4'(cs);
    x.ld = ld;
    x.er = er;
    x.st = st;
    x.bz = bz;
    x.fd = fd;
    q.push_back(x);
    gen_cyc++;
  endtask
  // one pass over the objects: a present object costs a start cycle plus the plotter wait,
  // an absent one a single cycle; a lat <= 0 plotter never answers, so the wait runs to timeout
  task automatic phase(input logic [4:0] on, input bit er, input int lat);
    for (int i = 0; i < 5; i++) begin
      if (on[i]) begin
        put(i, 0, er, 1, 1, 0);
        repeat (lat > 0 ? lat : PT) put(i, 0, er, 0, 1, 0);
        if (lat <= 0) begin
          if (gen_cyc < m_terr_cyc) m_terr_cyc = gen_cyc;
          if (!er) m_drawn[i] = 1'b0;
        end
      end else put(i, 0, er, 0, 1, 0);
    end
  endtask
  task automatic gen_frame(input logic [4:0] a, input int lat);
    phase(m_drawn, 1, lat);
    put(4, 1, 0, 0, 1, 0);
    m_drawn = a;
    phase(a, 0, lat);
    put(4, 0, 0, 0, 1, 1);
  endtask
  task automatic frame(input logic [4:0] a, input int lat, input bit pend);
    @(posedge clk); #1;
    log_s = "";
    plat = lat;
    alive = a;
    frame_tick = 1'b1;
    tick_cyc = cyc;
    gen_cyc = cyc;
    put(0, 0, 0, 0, 0, 0);
    gen_frame(a, lat);
    if (pend) begin
      put(0, 0, 0, 0, 0, 0);
      gen_frame(a, lat);
    end
    @(posedge clk); #1;
    frame_tick = 1'b0;
  endtask
  task automatic drain(input string name);
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check_int(name, int'(n < 3000), 1);
  endtask
  initial begin
    forever begin
      @(posedge clk); #1;
      if (plat < 0) plot_done = plot_start;
      else begin
        if (plot_start && plat > 0) due = cyc + plat;
        plot_done = cyc == due;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      r = q.size() != 0 ? q.pop_front() : '0;
      expv = {r, cyc >= m_ovr_cyc, cyc >= m_terr_cyc};
      act = {control_signal, load, erase, plot_start, busy, frame_done, overrun, timeout_err};
      vectors++;
      if (act !== expv) begin
        miscompares++;
        $display("FAIL cycle %0d outputs {cs,ld,er,st,bz,fd,ov,to}: got %b want %b", cyc, act, expv);
      end
      if (plot_start) log_s = {log_s, log_s.len() ? " " : "", $sformatf("%s%0d", erase ? "e" : "d", control_signal)};
      if (load) log_s = {log_s, log_s.len() ? " " : "", "L"};
      if (frame_done) begin
        log_s = {log_s, log_s.len() ? " " : "", "F"};
        fd_cyc = cyc;
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [4:0] a_pe, a_p, a_pe0;
    a_p = 5'(1 << OBJ_PLAYER);
    a_pe = a_p | 5'(1 << OBJ_E0);
    a_pe0 = a_pe | 5'(1 << OBJ_E3);
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check_int("reset outputs", int'({control_signal, load, erase, plot_start, busy, frame_done, overrun, timeout_err}), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    frame(5'b00000, 0, 0);
    drain("empty drain");
    check_int("empty tick-to-done", fd_cyc - tick_cyc, 12);
    check_str("empty log", log_s, "L F");
    frame(a_pe0, 3, 0);
    drain("first drain");
    check_str("first log", log_s, "L d0 d1 d4 F");
    frame(a_p, 3, 0);
    drain("second drain");
    check_str("second log", log_s, "e0 e1 e4 L d0 F");
    frame(a_p, -1, 0);
    drain("timeout drain");
    check_str("timeout log", log_s, "e0 L d0 F");
    check_int("timeout_err", int'(timeout_err), 1);
    frame(a_pe, 3, 1);
    repeat (2) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(posedge clk); #1 frame_tick = 1'b1;
    m_ovr_cyc = cyc + 1;
    @(posedge clk); #1 frame_tick = 1'b0;
    drain("pending drain");
    check_str("pending log", log_s, "L d0 d1 F e0 e1 L d0 d1 F");
    check_int("overrun", int'(overrun), 1);
    frame(a_p, 3, 0);
    repeat (13) @(posedge clk);
    #1;
    check_int("in draw wait", int'({busy, erase, plot_start}), 3'b100);
    reset = 1'b0;
    @(posedge clk); #1;
    q.delete();
    m_terr_cyc = INF;
    m_ovr_cyc = INF;
    m_drawn = '0;
    due = -1;
    check_int("mid-frame reset outputs", int'({control_signal, load, erase, plot_start, busy, frame_done, overrun, timeout_err}), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    frame(a_p, 3, 0);
    drain("after reset drain");
    check_str("after reset log", log_s, "L d0 F");
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
